// File: rtl/gpio_io_pkg.sv
// gpio_io_pkg -- shared definitions for the gpio_io block.
//   SW_W        : number of board switches
//   DIGITS      : number of 7-segment digits on the display
//   db_state_e  : switch debounce FSM states
//   SEG_*       : active-low segment images for 0-F, bit order {g,f,e,d,c,b,a}
//   SEG_TABLE   : the same images indexed by nibble value
//   HEX_ZERO    : full display image with every digit showing 0
package gpio_io_pkg;

  localparam int SW_W   = 18;
  localparam int DIGITS = 8;

  typedef enum logic [0:0] {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Leftmost entry is index 15, so SEG_TABLE[n] is the image for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  localparam logic [DIGITS*7-1:0] HEX_ZERO = {DIGITS{SEG_0}};

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational nibble to active-low 7-segment decoder.
//   nib : 4-bit value to display
//   seg : segment image {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decode
  import gpio_io_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/gpio_io.sv
// gpio_io -- switch debouncer and 8-digit display front end for a CPU GPIO port.
//   clk          : single clock, all state on posedge
//   rst          : synchronous active-low reset
//   sw_in        : raw asynchronous switches (18)
//   cpu_gpio_out : word written by the CPU, shown on the display
//   cpu_gpio_in  : {14'b0, debounced switches} returned to the CPU
//   hex_out      : 8 active-low digits, digit k in bits [7k+6:7k]
//   out_strobe   : one-cycle pulse when a new cpu_gpio_out value is accepted
//   disp_ovf     : displayed decimal value truncated (BCD build only)
// Build option: define GPIO_IO_BCD_EN to show the value in decimal through a
// sequential double-dabble converter; otherwise the display is hexadecimal
// and disp_ovf is tied low.
module gpio_io
  import gpio_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_W-1:0]       sw_in,
  input  logic [31:0]           cpu_gpio_out,
  output logic [31:0]           cpu_gpio_in,
  output logic [DIGITS*7-1:0]   hex_out,
  output logic                  out_strobe,
  output logic                  disp_ovf
);

  localparam logic [0:0]  IDLE     = DB_IDLE;
  localparam logic [0:0]  COUNT    = DB_COUNT;
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------
  // Switch synchronizer and debounce
  // ---------------------------------------------------------------
  logic [SW_W-1:0] sync1_reg;
  logic [SW_W-1:0] sync2_reg;
  logic [SW_W-1:0] cand_reg;
  logic [SW_W-1:0] stable_sw_reg;
  logic [15:0]     cnt_reg;
  logic [0:0]      state_reg;
  logic [31:0]     cpu_gpio_in_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg       <= '0;
      sync2_reg       <= '0;
      cand_reg        <= '0;
      stable_sw_reg   <= '0;
      cnt_reg         <= '0;
      state_reg       <= IDLE;
      cpu_gpio_in_reg <= '0;
    end else begin
      sync1_reg <= sw_in;
      sync2_reg <= sync1_reg;
      case (state_reg)
        IDLE: begin
          if (sync2_reg != stable_sw_reg) begin
            cand_reg  <= sync2_reg;
            cnt_reg   <= '0;
            state_reg <= COUNT;
          end
        end
        default: begin
          if (sync2_reg == cand_reg) begin
            if (cnt_reg == CNT_LAST) begin
              // The CPU word is loaded on the same edge as stable_sw so it
              // only ever moves when the debounced value moves.
              stable_sw_reg   <= cand_reg;
              cpu_gpio_in_reg <= {{(32-SW_W){1'b0}}, cand_reg};
              state_reg       <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end else if (sync2_reg == stable_sw_reg) begin
            state_reg <= IDLE;
          end else begin
            cand_reg <= sync2_reg;
            cnt_reg  <= '0;
          end
        end
      endcase
    end
  end

  assign cpu_gpio_in = cpu_gpio_in_reg;

  // ---------------------------------------------------------------
  // Output word capture and change strobe
  // ---------------------------------------------------------------
  logic [31:0] out_q_reg;
  logic [31:0] disp_val_reg;
  logic        strobe_reg;
  logic        load;

  assign load = (out_q_reg != disp_val_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q_reg    <= '0;
      disp_val_reg <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      out_q_reg  <= cpu_gpio_out;
      strobe_reg <= load;
      if (load) begin
        disp_val_reg <= out_q_reg;
      end
    end
  end

  assign out_strobe = strobe_reg;

  // ---------------------------------------------------------------
  // Display decode
  // ---------------------------------------------------------------
  logic [31:0]          nib_src;
  logic [DIGITS*7-1:0]  seg_img;
  logic [DIGITS*7-1:0]  hex_reg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
    seg7_decode u_dec (
      .nib (nib_src[4*gi +: 4]),
      .seg (seg_img[7*gi +: 7])
    );
  end

`ifdef GPIO_IO_BCD_EN
  // Double-dabble: 10 BCD digits cover the full 32-bit range; only the low
  // 8 are displayed and the upper two flag truncation.
  logic [31:0] bin_reg;
  logic [39:0] bcd_reg;
  logic [39:0] bcd_adj;
  logic [4:0]  iter_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ovf_reg;

  for (genvar gi = 0; gi < 10; gi++) begin : g_dabble
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      iter_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      hex_reg  <= HEX_ZERO;
    end else begin
      // A new value always restarts the converter (latest wins).
      if (load) begin
        bin_reg  <= out_q_reg;
        bcd_reg  <= '0;
        iter_reg <= '0;
        busy_reg <= 1'b1;
        done_reg <= 1'b0;
      end else if (busy_reg) begin
        bcd_reg  <= {bcd_adj[38:0], bin_reg[31]};
        bin_reg  <= {bin_reg[30:0], 1'b0};
        iter_reg <= iter_reg + 5'd1;
        if (iter_reg == 5'd31) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end else begin
        done_reg <= 1'b0;
      end
      // Extra stage after the last shift: display and overflow move together.
      if (done_reg) begin
        hex_reg <= seg_img;
        ovf_reg <= |bcd_reg[39:32];
      end
    end
  end

  assign nib_src  = bcd_reg[31:0];
  assign disp_ovf = ovf_reg;
`else
  // Hex image is decoded from the value being loaded so it is valid in the
  // same cycle as the strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hex_reg <= HEX_ZERO;
    end else if (load) begin
      hex_reg <= seg_img;
    end
  end

  assign nib_src  = out_q_reg;
  assign disp_ovf = 1'b0;
`endif

  assign hex_out = hex_reg;

endmodule

// File: tb/tb_gpio_io.sv
// tb_gpio_io -- directed self-checking bench for gpio_io.
module tb_gpio_io;

  localparam int DEB = 16;

  logic        clk;
  logic        rst;
  logic [17:0] sw_in;
  logic [31:0] cpu_gpio_out;
  logic [31:0] cpu_gpio_in;
  logic [55:0] hex_out;
  logic        out_strobe;
  logic        disp_ovf;

  int checks;
  int failures;
  int strobe_cnt;
  int base;
  int first;
  int bad;

  gpio_io #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .cpu_gpio_out (cpu_gpio_out),
    .cpu_gpio_in  (cpu_gpio_in),
    .hex_out      (hex_out),
    .out_strobe   (out_strobe),
    .disp_ovf     (disp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial strobe_cnt = 0;
  always @(negedge clk) begin
    if (out_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [55:0] hex_img(input logic [31:0] v);
    logic [55:0] r;
    for (int k = 0; k < 8; k++) r[7*k +: 7] = seg_of(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [55:0] dec_img(input logic [31:0] v);
    logic [55:0] r;
    int unsigned t;
    t = v % 32'd100000000;
    for (int k = 0; k < 8; k++) begin
      r[7*k +: 7] = seg_of(4'(t % 10));
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until cpu_gpio_in shows the target; -1 if it never does.
  task automatic wait_gpio_in(input logic [31:0] target, output int edge_n);
    edge_n = -1;
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      if (edge_n < 0 && cpu_gpio_in == target) edge_n = n;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    sw_in = '0;
    cpu_gpio_out = '0;

    // Reset state
    tick(3);
    check("rst_gpio_in", 64'(cpu_gpio_in), 64'd0);
    check("rst_strobe",  64'(out_strobe),  64'd0);
    check("rst_hex",     64'(hex_out),     64'(hex_img(32'd0)));
    check("rst_ovf",     64'(disp_ovf),    64'd0);
    base = strobe_cnt;
    rst = 1'b1;
    tick(10);
    check("idle_strobes", 64'(strobe_cnt - base), 64'd0);
    check("idle_hex",     64'(hex_out),           64'(hex_img(32'd0)));

    // Clean switch change: first sampling edge is edge 1
    sw_in = 18'h2A5F;
    wait_gpio_in(32'h0000_2A5F, first);
    check("deb_latency", 64'(first - 1), 64'(DEB + 2));
    check("deb_value",   64'(cpu_gpio_in), 64'h2A5F);

    // Bouncing bit 0 never settles long enough
    rst = 1'b0;
    sw_in = '0;
    tick(2);
    check("rst2_gpio_in", 64'(cpu_gpio_in), 64'd0);
    rst = 1'b1;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      if (n % 5 == 0) sw_in[0] = ~sw_in[0];
      tick(1);
      if (cpu_gpio_in != 32'd0) bad = bad + 1;
    end
    check("bounce_changes", 64'(bad), 64'd0);
    sw_in = '0;
    tick(25);
    check("bounce_settle", 64'(cpu_gpio_in), 64'd0);

    // Reset in the middle of a count
    sw_in = 18'h1;
    tick(7);
    rst = 1'b0;
    tick(2);
    check("midrst_gpio_in", 64'(cpu_gpio_in), 64'd0);
    rst = 1'b1;
    wait_gpio_in(32'h1, first);
    check("midrst_latency", 64'(first - 1), 64'(DEB + 2));
    check("midrst_value",   64'(cpu_gpio_in), 64'd1);
    check("no_strobes_yet", 64'(strobe_cnt - base), 64'd0);

`ifndef GPIO_IO_BCD_EN
    // Back-to-back values
    base = strobe_cnt;
    cpu_gpio_out = 32'hDEAD_BEEF;
    tick(1);
    check("s0_strobe", 64'(out_strobe), 64'd0);
    cpu_gpio_out = 32'h0000_0001;
    tick(1);
    check("s1_strobe", 64'(out_strobe), 64'd1);
    check("s1_hex",    64'(hex_out),    64'(hex_img(32'hDEAD_BEEF)));
    tick(1);
    check("s2_strobe", 64'(out_strobe), 64'd1);
    check("s2_hex",    64'(hex_out),    64'(hex_img(32'h0000_0001)));
    tick(1);
    check("s3_strobe", 64'(out_strobe), 64'd0);
    check("s3_hex",    64'(hex_out),    64'(hex_img(32'h0000_0001)));
    tick(5);
    check("strobe_count", 64'(strobe_cnt - base), 64'd2);
    cpu_gpio_out = 32'h89AB_CDEF;
    tick(2);
    check("s4_strobe", 64'(out_strobe), 64'd1);
    check("s4_hex",    64'(hex_out),    64'(hex_img(32'h89AB_CDEF)));
    check("s4_ovf",    64'(disp_ovf),   64'd0);
`else
    // Decimal conversion of a value above 10^8
    cpu_gpio_out = 32'd123456789;
    tick(2);
    check("bcd_a_strobe", 64'(out_strobe), 64'd1);
    tick(32);
    check("bcd_a_early",  64'(hex_out),  64'(dec_img(32'd0)));
    tick(1);
    check("bcd_a_hex",    64'(hex_out),  64'(dec_img(32'd123456789)));
    check("bcd_a_ovf",    64'(disp_ovf), 64'd1);
    // Restart mid-conversion: 7 is abandoned, 42 wins
    cpu_gpio_out = 32'd7;
    tick(2);
    check("bcd_b_strobe", 64'(out_strobe), 64'd1);
    tick(10);
    cpu_gpio_out = 32'd42;
    tick(2);
    check("bcd_c_strobe", 64'(out_strobe), 64'd1);
    tick(21);
    check("bcd_b_held",   64'(hex_out),  64'(dec_img(32'd123456789)));
    tick(11);
    check("bcd_c_early",  64'(hex_out),  64'(dec_img(32'd123456789)));
    tick(1);
    check("bcd_c_hex",    64'(hex_out),  64'(dec_img(32'd42)));
    check("bcd_c_ovf",    64'(disp_ovf), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
